// File: rtl/cpu_if.sv
// Instruction fetch and data memory bus between the core and its memories.
interface cpu_if;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic [31:0] memory_address;
   logic [31:0] memory_out;
   logic [31:0] memory_write;
   logic [3:0]  memory_byte_enable;
   logic        memory_we;

   modport master (
      output pc, memory_address, memory_write, memory_byte_enable, memory_we,
      input  instruction, memory_out
   );

   modport slave (
      input  pc, memory_address, memory_write, memory_byte_enable, memory_we,
      output instruction, memory_out
   );
endinterface

// File: rtl/cpu.sv
// Single-cycle RV32I core: one instruction per clock, halts on EBREAK until reset.
//
// state  | meaning
// S_RUN  | executing one instruction per clock
// S_HALT | EBREAK seen; pc frozen, no register or memory writes until reset
module cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic   clk,
   input  logic   rst_n,
   cpu_if.master  bus,
   output logic   ebreak
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t      state_q, state_d;
   logic        exec_en;
   logic [31:0] pc_q;
   logic [31:0] regs [32];

   logic [31:0] instr;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val;
   logic        is_ebreak;

   logic [31:0] ls_addr;
   logic [31:0] lane_word;
   logic [15:0] lane_half;

   logic        rd_we;
   logic [31:0] rd_data;
   logic [31:0] pc_next;
   logic        is_store;
   logic [31:0] mem_addr;
   logic [31:0] store_data;
   logic [3:0]  store_be;
   logic        taken;

   assign instr  = bus.instruction;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   assign is_ebreak = (instr == EBREAK_WORD);

   assign ls_addr   = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign lane_word = bus.memory_out >> {ls_addr[1:0], 3'b000};
   assign lane_half = ls_addr[1] ? bus.memory_out[31:16] : bus.memory_out[15:0];

   // Run/halt state register.
   always_ff @(posedge clk) begin
      if (rst_n) state_q <= S_RUN;
      else       state_q <= state_d;
   end

   // Run/halt transitions; an instruction only commits while running and not EBREAK.
   always_comb begin
      state_d = state_q;
      exec_en = 1'b0;
      case (state_q)
         S_RUN: begin
            if (!rst_n) begin
               if (is_ebreak) state_d = S_HALT;
               else           exec_en = 1'b1;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   // Decode/execute: writeback value, next pc and memory request.
   always_comb begin
      rd_we      = 1'b0;
      rd_data    = 32'd0;
      pc_next    = pc_q + 32'd4;
      is_store   = 1'b0;
      mem_addr   = 32'd0;
      store_data = 32'd0;
      store_be   = 4'b0000;
      taken      = 1'b0;
      case (opcode)
         OP_LUI: begin
            rd_we   = 1'b1;
            rd_data = imm_u;
         end
         OP_AUIPC: begin
            rd_we   = 1'b1;
            rd_data = pc_q + imm_u;
         end
         OP_JAL: begin
            rd_we   = 1'b1;
            rd_data = pc_q + 32'd4;
            pc_next = pc_q + imm_j;
         end
         OP_JALR: begin
            if (funct3 == 3'd0) begin
               rd_we   = 1'b1;
               rd_data = pc_q + 32'd4;
               pc_next = (rs1_val + imm_i) & ~32'd1;
            end
         end
         OP_BRANCH: begin
            case (funct3)
               3'd0: taken = (rs1_val == rs2_val);
               3'd1: taken = (rs1_val != rs2_val);
               3'd4: taken = ($signed(rs1_val) <  $signed(rs2_val));
               3'd5: taken = ($signed(rs1_val) >= $signed(rs2_val));
               3'd6: taken = (rs1_val <  rs2_val);
               3'd7: taken = (rs1_val >= rs2_val);
               default: taken = 1'b0;
            endcase
            if (taken) pc_next = pc_q + imm_b;
         end
         OP_LOAD: begin
            mem_addr = ls_addr;
            rd_we    = 1'b1;
            case (funct3)
               3'd0: rd_data = {{24{lane_word[7]}}, lane_word[7:0]};
               3'd1: rd_data = {{16{lane_half[15]}}, lane_half};
               3'd2: rd_data = bus.memory_out;
               3'd4: rd_data = {24'd0, lane_word[7:0]};
               3'd5: rd_data = {16'd0, lane_half};
               default: rd_we = 1'b0;
            endcase
         end
         OP_STORE: begin
            mem_addr = ls_addr;
            is_store = 1'b1;
            case (funct3)
               3'd0: begin
                  store_data = {4{rs2_val[7:0]}};
                  store_be   = 4'b0001 << ls_addr[1:0];
               end
               3'd1: begin
                  store_data = {2{rs2_val[15:0]}};
                  store_be   = ls_addr[1] ? 4'b1100 : 4'b0011;
               end
               3'd2: begin
                  store_data = rs2_val;
                  store_be   = 4'b1111;
               end
               default: is_store = 1'b0;
            endcase
         end
         OP_IMM: begin
            rd_we = 1'b1;
            case (funct3)
               3'd0: rd_data = rs1_val + imm_i;
               3'd2: rd_data = {31'd0, $signed(rs1_val) < $signed(imm_i)};
               3'd3: rd_data = {31'd0, rs1_val < imm_i};
               3'd4: rd_data = rs1_val ^ imm_i;
               3'd6: rd_data = rs1_val | imm_i;
               3'd7: rd_data = rs1_val & imm_i;
               3'd1: begin
                  if (funct7 == 7'h00) rd_data = rs1_val << rs2;
                  else                 rd_we   = 1'b0;
               end
               3'd5: begin
                  if (funct7 == 7'h00)      rd_data = rs1_val >> rs2;
                  else if (funct7 == 7'h20) rd_data = 32'($signed(rs1_val) >>> rs2);
                  else                      rd_we   = 1'b0;
               end
               default: rd_we = 1'b0;
            endcase
         end
         OP_REG: begin
            rd_we = 1'b1;
            case ({funct7, funct3})
               {7'h00, 3'd0}: rd_data = rs1_val + rs2_val;
               {7'h20, 3'd0}: rd_data = rs1_val - rs2_val;
               {7'h00, 3'd1}: rd_data = rs1_val << rs2_val[4:0];
               {7'h00, 3'd2}: rd_data = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
               {7'h00, 3'd3}: rd_data = {31'd0, rs1_val < rs2_val};
               {7'h00, 3'd4}: rd_data = rs1_val ^ rs2_val;
               {7'h00, 3'd5}: rd_data = rs1_val >> rs2_val[4:0];
               {7'h20, 3'd5}: rd_data = 32'($signed(rs1_val) >>> rs2_val[4:0]);
               {7'h00, 3'd6}: rd_data = rs1_val | rs2_val;
               {7'h00, 3'd7}: rd_data = rs1_val & rs2_val;
               default:       rd_we   = 1'b0;
            endcase
         end
         default: rd_we = 1'b0;
      endcase
   end

   // Program counter: holds while halted or on EBREAK.
   always_ff @(posedge clk) begin
      if (rst_n)        pc_q <= RESET_PC;
      else if (exec_en) pc_q <= pc_next;
   end

   // Register file write port; x0 is never written.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (exec_en && rd_we && (rd != 5'd0)) begin
         regs[rd] <= rd_data;
      end
   end

   assign bus.pc                 = pc_q;
   assign bus.memory_address     = mem_addr;
   assign bus.memory_write       = store_data;
   assign bus.memory_we          = exec_en & is_store;
   assign bus.memory_byte_enable = (exec_en & is_store) ? store_be : 4'b0000;
   assign ebreak                 = is_ebreak & ~rst_n;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle core with a small program/data memory model.
module tb_cpu;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic ebreak;
   logic mem_init = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   logic [31:0] imem [64];
   logic [31:0] dmem [16];

   cpu_if bus();

   cpu #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .ebreak(ebreak)
   );

   always #5 clk = ~clk;

   assign bus.instruction = imem[bus.pc[7:2]];
   assign bus.memory_out  = dmem[bus.memory_address[5:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) dmem[i] <= 32'hDEAD_BEEF;
      end else if (bus.memory_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.memory_byte_enable[b])
               dmem[bus.memory_address[5:2]][8*b +: 8] <= bus.memory_write[8*b +: 8];
      end
   end

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                         input logic [2:0] f3, input logic [31:0] rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd,
                                         input logic [6:0] op);
      return {imm[19:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [2:0] f3,
                                         input logic [31:0] rd);
      return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
   endtask

   task automatic start_prog();
      rst_n    = 1'b1;
      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
      rst_n    = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      // Arithmetic, store, x0, NOP-class encodings and EBREAK halt.
      clear_imem();
      imem[0] = enc_i(5, 0, 0, 1, 7'h13);
      imem[1] = enc_i(-3, 0, 0, 2, 7'h13);
      imem[2] = enc_r(7'h00, 2, 1, 0, 3);
      imem[3] = enc_s(0, 3, 0, 3'd2);
      imem[4] = enc_i(7, 0, 0, 0, 7'h13);
      imem[5] = enc_s(4, 0, 0, 3'd2);
      imem[6] = 32'hFFFF_FFFF;
      imem[7] = 32'h0000_000F;
      imem[8] = 32'h0010_0073;
      rst_n    = 1'b1;
      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
      chk("reset_pc", bus.pc, 32'h0);
      chk("reset_we", {31'd0, bus.memory_we}, 32'd0);
      chk("reset_be", {28'd0, bus.memory_byte_enable}, 32'd0);
      chk("reset_ebreak", {31'd0, ebreak}, 32'd0);
      rst_n = 1'b0;
      step(); step(); step();
      chk("sw_we", {31'd0, bus.memory_we}, 32'd1);
      chk("sw_be", {28'd0, bus.memory_byte_enable}, 32'hF);
      chk("sw_data", bus.memory_write, 32'h0000_0002);
      chk("sw_addr", bus.memory_address, 32'h0);
      step();
      chk("pc_after4", bus.pc, 32'd16);
      chk("mem0_sum", dmem[0], 32'h0000_0002);
      step();
      chk("x0_reads0", bus.memory_write, 32'h0);
      step();
      chk("illegal_we", {31'd0, bus.memory_we}, 32'd0);
      chk("illegal_be", {28'd0, bus.memory_byte_enable}, 32'd0);
      step(); step();
      chk("ebreak_pc", bus.pc, 32'h20);
      chk("ebreak_hi", {31'd0, ebreak}, 32'd1);
      chk("ebreak_we", {31'd0, bus.memory_we}, 32'd0);
      step(); step(); step();
      chk("halt_pc", bus.pc, 32'h20);
      chk("halt_ebreak", {31'd0, ebreak}, 32'd1);
      chk("mem1_x0", dmem[1], 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_ebreak_low", {31'd0, ebreak}, 32'd0);
      step();
      chk("rst_pc_clear", bus.pc, 32'h0);

      // Reset asserted while a store is current: store must not land.
      clear_imem();
      imem[0] = enc_i(32'h55, 0, 0, 1, 7'h13);
      imem[1] = enc_s(8, 1, 0, 3'd2);
      start_prog();
      step();
      chk("pre_rst_we", {31'd0, bus.memory_we}, 32'd1);
      chk("pre_rst_data", bus.memory_write, 32'h55);
      rst_n = 1'b1;
      #1;
      chk("midrst_we", {31'd0, bus.memory_we}, 32'd0);
      chk("midrst_be", {28'd0, bus.memory_byte_enable}, 32'd0);
      step();
      chk("midrst_mem", dmem[2], 32'hDEAD_BEEF);
      chk("midrst_pc", bus.pc, 32'h0);

      // Byte/halfword stores and loads.
      clear_imem();
      imem[0]  = enc_u(32'h80000, 1, 7'h37);
      imem[1]  = enc_i(240, 1, 0, 1, 7'h13);
      imem[2]  = enc_s(3, 1, 0, 3'd0);
      imem[3]  = enc_i(3, 0, 0, 2, 7'h03);
      imem[4]  = enc_i(3, 0, 4, 3, 7'h03);
      imem[5]  = enc_s(4, 2, 0, 3'd2);
      imem[6]  = enc_s(8, 3, 0, 3'd2);
      imem[7]  = enc_s(6, 3, 0, 3'd1);
      imem[8]  = enc_i(4, 0, 1, 4, 7'h03);
      imem[9]  = enc_i(6, 0, 5, 5, 7'h03);
      imem[10] = enc_s(12, 4, 0, 3'd2);
      imem[11] = enc_s(16, 5, 0, 3'd2);
      start_prog();
      step(); step();
      chk("sb_be", {28'd0, bus.memory_byte_enable}, 32'h8);
      chk("sb_data", bus.memory_write, 32'hF0F0_F0F0);
      chk("sb_addr", bus.memory_address, 32'h3);
      step();
      chk("lb_addr", bus.memory_address, 32'h3);
      step(); step();
      chk("lb_sext", bus.memory_write, 32'hFFFF_FFF0);
      step();
      chk("lbu_zext", bus.memory_write, 32'h0000_00F0);
      chk("sb_lane", dmem[0], 32'hF0AD_BEEF);
      step();
      chk("sh_be", {28'd0, bus.memory_byte_enable}, 32'hC);
      chk("sh_data", bus.memory_write, 32'h00F0_00F0);
      step(); step(); step();
      chk("lh_sext", bus.memory_write, 32'hFFFF_FFF0);
      step();
      chk("lhu_upper", bus.memory_write, 32'h0000_00F0);

      // Branches and JAL.
      clear_imem();
      imem[0]  = enc_i(-1, 0, 0, 1, 7'h13);
      imem[1]  = enc_i(1, 0, 0, 2, 7'h13);
      imem[2]  = enc_j(12, 6);
      imem[5]  = enc_b(8, 2, 1, 3'd4);
      imem[7]  = enc_b(8, 2, 1, 3'd6);
      imem[8]  = enc_b(8, 1, 2, 3'd5);
      imem[10] = enc_b(8, 1, 2, 3'd7);
      imem[11] = enc_b(8, 2, 1, 3'd1);
      imem[13] = enc_s(0, 6, 0, 3'd2);
      imem[14] = enc_b(8, 2, 1, 3'd0);
      start_prog();
      step(); step(); step();
      chk("jal_pc", bus.pc, 32'd20);
      step();
      chk("blt_taken", bus.pc, 32'd28);
      step();
      chk("bltu_not", bus.pc, 32'd32);
      step();
      chk("bge_taken", bus.pc, 32'd40);
      step();
      chk("bgeu_not", bus.pc, 32'd44);
      step();
      chk("bne_taken", bus.pc, 32'd52);
      chk("jal_link", bus.memory_write, 32'd12);
      step(); step();
      chk("beq_not", bus.pc, 32'd60);

      // AUIPC, JALR with odd target, LUI.
      clear_imem();
      imem[0]  = enc_i(32'h41, 0, 0, 1, 7'h13);
      imem[1]  = enc_u(1, 7, 7'h17);
      imem[2]  = enc_i(1, 1, 0, 0, 7'h67);
      imem[16] = enc_s(0, 7, 0, 3'd2);
      imem[17] = enc_u(32'h12345, 5, 7'h37);
      imem[18] = enc_s(4, 5, 0, 3'd2);
      start_prog();
      step(); step(); step();
      chk("jalr_pc", bus.pc, 32'h42);
      chk("auipc", bus.memory_write, 32'h0000_1004);
      step(); step();
      chk("lui", bus.memory_write, 32'h1234_5000);
      chk("lui_st_addr", bus.memory_address, 32'h4);

      // Shifts, compares, SUB, XORI, SLL.
      clear_imem();
      imem[0]  = enc_i(-16, 0, 0, 1, 7'h13);
      imem[1]  = enc_i(32'h402, 1, 5, 2, 7'h13);
      imem[2]  = enc_i(28, 1, 5, 3, 7'h13);
      imem[3]  = enc_r(7'h20, 1, 3, 0, 4);
      imem[4]  = enc_r(7'h00, 3, 1, 2, 5);
      imem[5]  = enc_r(7'h00, 3, 1, 3, 6);
      imem[6]  = enc_i(32'hFF, 1, 4, 7, 7'h13);
      imem[7]  = enc_r(7'h00, 3, 3, 1, 8);
      imem[8]  = enc_s(0, 2, 0, 3'd2);
      imem[9]  = enc_s(4, 3, 0, 3'd2);
      imem[10] = enc_s(8, 4, 0, 3'd2);
      imem[11] = enc_s(12, 5, 0, 3'd2);
      imem[12] = enc_s(16, 6, 0, 3'd2);
      imem[13] = enc_s(20, 7, 0, 3'd2);
      imem[14] = enc_s(24, 8, 0, 3'd2);
      start_prog();
      repeat (8) step();
      chk("srai", bus.memory_write, 32'hFFFF_FFFC);
      step();
      chk("srli", bus.memory_write, 32'h0000_000F);
      step();
      chk("sub", bus.memory_write, 32'h0000_001F);
      step();
      chk("slt", bus.memory_write, 32'h0000_0001);
      step();
      chk("sltu", bus.memory_write, 32'h0000_0000);
      step();
      chk("xori", bus.memory_write, 32'hFFFF_FF0F);
      step();
      chk("sll", bus.memory_write, 32'h0007_8000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
